// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: funnels NUM_PORTS requesters onto one memory bus, one access in flight.
// Fixed-priority or round-robin grant; an optional ack timeout ends the access with o_err.
module mem_bus_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ARB_MODE  = 1,
  parameter int TIMEOUT   = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS-1:0]        i_stb,
  input  logic [NUM_PORTS-1:0]        i_wr_en,
  input  logic [NUM_PORTS*ADDR_W-1:0] i_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] i_wdata,
  output logic [NUM_PORTS-1:0]        o_ack,
  output logic [NUM_PORTS-1:0]        o_err,
  output logic [DATA_W-1:0]           o_rdata,
  output logic [NUM_PORTS-1:0]        o_grant,
  output logic                        o_m_stb,
  output logic                        o_m_wr_en,
  output logic [ADDR_W-1:0]           o_m_addr,
  output logic [DATA_W-1:0]           o_m_wdata,
  input  logic [DATA_W-1:0]           i_m_rdata,
  input  logic                        i_m_ack
);

  // state  | meaning
  // S_IDLE | no access in flight, arbitrating i_stb
  // S_BUSY | memory strobe asserted, waiting for i_m_ack or timeout
  // S_RESP | one-cycle o_ack / o_err pulse to the granted port

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [NUM_PORTS-1:0] r_grant;
  logic [IDX_W-1:0]     r_last;
  logic [ADDR_W-1:0]    r_addr;
  logic [DATA_W-1:0]    r_wdata;
  logic                 r_wr_en;
  logic [DATA_W-1:0]    r_rdata;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_to;

  logic [NUM_PORTS-1:0] w_win_oh;
  logic [IDX_W-1:0]     w_win_idx;
  logic [ADDR_W-1:0]    w_sel_addr;
  logic [DATA_W-1:0]    w_sel_wdata;
  logic                 w_sel_wr;
  logic                 w_expire;

  // Each port gets a rank (0 = highest priority); the requesting port with the lowest rank wins.
  always_comb begin
    int v_best;
    int v_rank;
    v_best    = NUM_PORTS;
    v_rank    = 0;
    w_win_idx = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      v_rank = (ARB_MODE == 0) ? k : (k + NUM_PORTS - 1 - int'(r_last)) % NUM_PORTS;
      if (i_stb[k] && (v_rank < v_best)) begin
        v_best    = v_rank;
        w_win_idx = IDX_W'(k);
      end
    end
    w_win_oh = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      w_win_oh[k] = (v_best < NUM_PORTS) && (IDX_W'(k) == w_win_idx);
    end
  end

  always_comb begin
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_wr    = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (w_win_oh[k]) begin
        w_sel_addr  = i_addr[k*ADDR_W +: ADDR_W];
        w_sel_wdata = i_wdata[k*DATA_W +: DATA_W];
        w_sel_wr    = i_wr_en[k];
      end
    end
  end

  assign w_expire = (TIMEOUT > 0) && (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // i_m_ack wins over an expiring timer in the same cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (|i_stb) w_next = S_BUSY;
      S_BUSY:  if (i_m_ack || w_expire) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_m_stb   = (r_state == S_BUSY);
    o_m_wr_en = (r_state == S_BUSY) && r_wr_en;
    o_m_addr  = r_addr;
    o_m_wdata = r_wdata;
    o_rdata   = r_rdata;
    o_grant   = r_grant;
    o_ack     = '0;
    o_err     = '0;
    if (r_state == S_RESP) begin
      if (r_to) o_err = r_grant;
      else      o_ack = r_grant;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant <= '0;
      r_last  <= IDX_W'(NUM_PORTS - 1);
      r_addr  <= '0;
      r_wdata <= '0;
      r_wr_en <= 1'b0;
      r_rdata <= '0;
      r_cnt   <= '0;
      r_to    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|i_stb) begin
            r_grant <= w_win_oh;
            r_last  <= w_win_idx;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_wr_en <= w_sel_wr;
            r_cnt   <= CNT_LOAD;
            r_to    <= 1'b0;
          end
        end
        S_BUSY: begin
          if (i_m_ack)       r_rdata <= i_m_rdata;
          else if (w_expire) r_to    <= 1'b1;
          else               r_cnt   <= r_cnt - 1'b1;
        end
        S_RESP:  r_grant <= '0;
        default: r_grant <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench: a round-robin and a fixed-priority instance share stimulus;
// table vectors, hand-written corner sequences, then randomized transactions vs a reference model.
module tb_mem_bus_arbiter;
  localparam int NP = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NP-1:0] stb, wr;
  logic [NP*AW-1:0] addr;
  logic [NP*DW-1:0] wdata;
  logic m_ack;
  logic [DW-1:0] m_rdata;

  logic [NP-1:0] rr_ack, rr_err, rr_grant, fp_ack, fp_err, fp_grant;
  logic rr_m_stb, rr_m_wr, fp_m_stb, fp_m_wr;
  logic [AW-1:0] rr_m_addr, fp_m_addr;
  logic [DW-1:0] rr_m_wdata, rr_rdata, fp_m_wdata, fp_rdata;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1), .TIMEOUT(TO)) u_rr (
    .clk(clk), .rst_n(rst_n), .i_stb(stb), .i_wr_en(wr), .i_addr(addr), .i_wdata(wdata),
    .o_ack(rr_ack), .o_err(rr_err), .o_rdata(rr_rdata), .o_grant(rr_grant),
    .o_m_stb(rr_m_stb), .o_m_wr_en(rr_m_wr), .o_m_addr(rr_m_addr), .o_m_wdata(rr_m_wdata),
    .i_m_rdata(m_rdata), .i_m_ack(m_ack));

  mem_bus_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0), .TIMEOUT(TO)) u_fp (
    .clk(clk), .rst_n(rst_n), .i_stb(stb), .i_wr_en(wr), .i_addr(addr), .i_wdata(wdata),
    .o_ack(fp_ack), .o_err(fp_err), .o_rdata(fp_rdata), .o_grant(fp_grant),
    .o_m_stb(fp_m_stb), .o_m_wr_en(fp_m_wr), .o_m_addr(fp_m_addr), .o_m_wdata(fp_m_wdata),
    .i_m_rdata(m_rdata), .i_m_ack(m_ack));

  int checks = 0;
  int errors = 0;
  int last_rr;
  logic [31:0] mdl_rdata;

  typedef struct {
    logic [1:0]  stb;
    int          d;
    logic [31:0] rd;
    logic [31:0] a0;
    logic [1:0]  wr;
    int          rr_win;
    int          fp_win;
    bit          err;
    logic [31:0] rdata;
    int          cyc;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_rr_ctl"}, {rr_ack, rr_err, rr_grant, rr_m_stb, rr_m_wr}, 64'd0);
    chk({tag, "_fp_ctl"}, {fp_ack, fp_err, fp_grant, fp_m_stb, fp_m_wr}, 64'd0);
  endtask

  // Called at #1 after an edge with both DUTs idle; returns the same way.
  // d = BUSY cycle (1-based) in which memory acks; d > TO means the ack never comes in time.
  task automatic do_txn(input logic [1:0] s, input int d, input logic [31:0] rd, input logic [31:0] a0,
                        input logic [1:0] w, input int rr_win, input int fp_win, input bit err,
                        input logic [31:0] exp_rd, input int exp_cyc);
    logic [31:0] a[2];
    logic [31:0] wd[2];
    logic [1:0]  rr_oh, fp_oh;
    int cyc;
    a[0] = a0; a[1] = $urandom; wd[0] = $urandom; wd[1] = $urandom;
    rr_oh = 2'(1 << rr_win);
    fp_oh = 2'(1 << fp_win);
    stb = s; wr = w; addr = {a[1], a[0]}; wdata = {wd[1], wd[0]};
    @(posedge clk); #1;
    chk("rr_grant", rr_grant, rr_oh);
    chk("fp_grant", fp_grant, fp_oh);
    chk("rr_m_addr", rr_m_addr, a[rr_win]);
    chk("fp_m_addr", fp_m_addr, a[fp_win]);
    chk("rr_m_wdata", rr_m_wdata, wd[rr_win]);
    chk("fp_m_wdata", fp_m_wdata, wd[fp_win]);
    chk("rr_m_wr", rr_m_wr, w[rr_win]);
    chk("fp_m_wr", fp_m_wr, w[fp_win]);
    cyc = 0;
    while (rr_m_stb === 1'b1 && cyc < 12) begin
      chk("rr_m_addr_hold", rr_m_addr, a[rr_win]);
      chk("fp_m_stb_busy", fp_m_stb, 1'b1);
      chk("rr_ack_busy", {rr_ack, rr_err}, 64'd0);
      cyc++;
      m_ack   = (cyc == d);
      m_rdata = (cyc == d) ? rd : $urandom;
      @(posedge clk); #1;
      m_ack   = 1'b0;
      m_rdata = $urandom;
    end
    chk("m_stb_cycles", cyc, exp_cyc);
    chk("fp_m_stb_resp", fp_m_stb, 1'b0);
    stb = 2'b00;
    chk("rr_ack", rr_ack, err ? 2'b00 : rr_oh);
    chk("rr_err", rr_err, err ? rr_oh : 2'b00);
    chk("fp_ack", fp_ack, err ? 2'b00 : fp_oh);
    chk("fp_err", fp_err, err ? fp_oh : 2'b00);
    chk("rr_grant_resp", rr_grant, rr_oh);
    chk("rr_rdata", rr_rdata, exp_rd);
    chk("fp_rdata", fp_rdata, exp_rd);
    @(posedge clk); #1;
    chk_quiet("after_resp");
    last_rr   = rr_win;
    mdl_rdata = exp_rd;
  endtask

  initial begin
    logic [1:0] s, w;
    int d, rrw, fpw;
    bit e;
    logic [31:0] rd;

    stb = '0; wr = '0; addr = '0; wdata = '0; m_ack = 1'b0; m_rdata = '0;
    last_rr = NP - 1;
    mdl_rdata = '0;

    tbl[0] = '{2'b11, 1, 32'hA1A1_0001, 32'h0000_0200, 2'b11, 0, 0, 1'b0, 32'hA1A1_0001, 1};
    tbl[1] = '{2'b11, 2, 32'hA2A2_0002, 32'h0000_0204, 2'b01, 1, 0, 1'b0, 32'hA2A2_0002, 2};
    tbl[2] = '{2'b11, 1, 32'hA3A3_0003, 32'h0000_0208, 2'b10, 0, 0, 1'b0, 32'hA3A3_0003, 1};
    tbl[3] = '{2'b11, 3, 32'hA4A4_0004, 32'h0000_020C, 2'b00, 1, 0, 1'b0, 32'hA4A4_0004, 3};
    tbl[4] = '{2'b10, 1, 32'hA5A5_0005, 32'h0000_0210, 2'b10, 1, 1, 1'b0, 32'hA5A5_0005, 1};
    tbl[5] = '{2'b01, 2, 32'hDEAD_BEEF, 32'h0000_0100, 2'b00, 0, 0, 1'b0, 32'hDEAD_BEEF, 2};
    tbl[6] = '{2'b10, 7, 32'hA7A7_0007, 32'h0000_0300, 2'b11, 1, 1, 1'b1, 32'hDEAD_BEEF, 4};
    tbl[7] = '{2'b11, 4, 32'h1234_5678, 32'h0000_0304, 2'b00, 0, 0, 1'b0, 32'h1234_5678, 4};
    tbl[8] = '{2'b01, 5, 32'hA9A9_0009, 32'h0000_0308, 2'b01, 0, 0, 1'b1, 32'h1234_5678, 4};
    tbl[9] = '{2'b11, 1, 32'hAAAA_000A, 32'h0000_030C, 2'b11, 1, 0, 1'b0, 32'hAAAA_000A, 1};

    repeat (3) @(posedge clk);
    #1;
    chk_quiet("reset");
    chk("reset_rr_data", {rr_m_addr, rr_m_wdata}, 64'd0);
    chk("reset_rr_rdata", rr_rdata, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++)
      do_txn(tbl[i].stb, tbl[i].d, tbl[i].rd, tbl[i].a0, tbl[i].wr,
             tbl[i].rr_win, tbl[i].fp_win, tbl[i].err, tbl[i].rdata, tbl[i].cyc);

    // Stray memory ack while idle must not disturb anything.
    m_ack = 1'b1; m_rdata = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    m_ack = 1'b0;
    chk_quiet("stray_ack");
    chk("stray_rr_rdata", rr_rdata, mdl_rdata);
    chk("stray_fp_rdata", fp_rdata, mdl_rdata);
    @(posedge clk); #1;
    chk_quiet("stray_ack_next");

    // Reset asserted mid-BUSY clears outputs without waiting for a clock edge.
    stb = 2'b11; addr = {$urandom, $urandom}; wdata = {$urandom, $urandom}; wr = 2'b11;
    @(posedge clk); #1;
    chk("pre_reset_busy", rr_m_stb, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk_quiet("async_reset");
    chk("async_rr_data", {rr_m_addr, rr_m_wdata}, 64'd0);
    chk("async_fp_data", {fp_m_addr, fp_m_wdata}, 64'd0);
    chk("async_rdata", {rr_rdata, fp_rdata}, 64'd0);
    stb = 2'b00;
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk_quiet("post_reset");
    last_rr = NP - 1;
    mdl_rdata = '0;
    do_txn(2'b10, 2, 32'h0BAD_F00D, 32'h0000_0400, 2'b00, 1, 1, 1'b0, 32'h0BAD_F00D, 2);

    // Randomized transactions against the reference arbitration/timeout rules.
    for (int n = 0; n < 150; n++) begin
      s  = 2'($urandom_range(1, 3));
      d  = $urandom_range(1, 6);
      rd = $urandom;
      w  = 2'($urandom);
      rrw = -1;
      for (int i = 1; i <= NP; i++) begin
        int p;
        p = (last_rr + i) % NP;
        if (rrw < 0 && ((s >> p) & 2'b01) != 2'b00) rrw = p;
      end
      fpw = (s & 2'b01) != 2'b00 ? 0 : 1;
      e = (d > TO);
      do_txn(s, d, rd, $urandom, w, rrw, fpw, e, e ? mdl_rdata : rd, e ? TO : d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
